// File: rtl/alu_flag_unit_if.sv
// Operand/result bundle between the compare stage and the subtract-and-flag engine.
// Latency: none, wires only.
// Backpressure: none; start is a request pulse, done marks the result.
interface alu_flag_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             z;
  logic             n;
  logic             v;

  // Requester side: issues operands and consumes the result and flags.
  modport master (
    output start, a, b,
    input  busy, done, diff, z, n, v
  );

  // Engine side.
  modport slave (
    input  start, a, b,
    output busy, done, diff, z, n, v
  );
endinterface

// File: rtl/alu_flag_unit.sv
// Multi-cycle a-b engine, CHUNK bits per cycle LSB first, producing diff and z/n/v flags.
// Latency: NCHUNK+1 cycles from accepted start to the one-cycle done pulse.
// Backpressure: start is accepted only in IDLE or DONE; start while busy is dropped.
module alu_flag_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_flag_unit_if.slave bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int BW     = $clog2(WIDTH) + 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic             load;

  // Latched operands; b is kept inverted so every slice is a plain add.
  logic [WIDTH-1:0] a_q, nb_q;
  // Working result, only copied to the outputs when the last slice lands.
  logic [WIDTH-1:0] acc_q, acc_nx;
  logic             carry_q, zero_q;
  logic [IW-1:0]    idx_q;

  logic [WIDTH-1:0] diff_q;
  logic             z_q, n_q, v_q;

  logic [BW-1:0]    base;
  logic [CHUNK:0]   sum;
  logic             last;
  logic             slice_zero;

  // Current slice add and the working result with that slice merged in.
  always_comb begin
    base       = BW'(idx_q) * BW'(CHUNK);
    sum        = {1'b0, a_q[base +: CHUNK]} + {1'b0, nb_q[base +: CHUNK]}
               + {{CHUNK{1'b0}}, carry_q};
    acc_nx     = acc_q;
    acc_nx[base +: CHUNK] = sum[CHUNK-1:0];
    slice_zero = (sum[CHUNK-1:0] == '0);
    last       = (idx_q == LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state and operand-load decision.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      IDLE: if (bus.start) begin
        load     = 1'b1;
        state_nx = RUN;
      end
      RUN: if (last) state_nx = DONE;
      DONE: begin
        if (bus.start) begin
          load     = 1'b1;
          state_nx = RUN;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Slice datapath; outputs are written only on the final slice (DONE entry).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q     <= '0;
      nb_q    <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      idx_q   <= '0;
      diff_q  <= '0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else if (load) begin
      a_q     <= bus.a;
      nb_q    <= ~bus.b;
      carry_q <= 1'b1;
      zero_q  <= 1'b1;
      idx_q   <= '0;
    end else if (state == RUN) begin
      acc_q   <= acc_nx;
      carry_q <= sum[CHUNK];
      zero_q  <= zero_q & slice_zero;
      idx_q   <= last ? '0 : idx_q + 1'b1;
      if (last) begin
        diff_q <= acc_nx;
        n_q    <= sum[CHUNK-1];
        z_q    <= zero_q & slice_zero;
        // Operand signs differ (a sign equals inverted-b sign) and result sign flipped from a.
        v_q    <= (a_q[WIDTH-1] == nb_q[WIDTH-1]) & (sum[CHUNK-1] != a_q[WIDTH-1]);
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.diff = diff_q;
  assign bus.z    = z_q;
  assign bus.n    = n_q;
  assign bus.v    = v_q;
endmodule

// File: tb/tb_alu_flag_unit.sv
// Directed bench for alu_flag_unit: default 32/8 instance plus a single-slice 16/16 instance.
// Expected values are hand-computed constants.
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_alu_flag_unit;
  logic clk;
  logic reset_n;
  int   tests_run;
  int   tests_failed;

  alu_flag_unit_if #(.WIDTH(32)) bus ();
  alu_flag_unit_if #(.WIDTH(16)) bus16 ();

  alu_flag_unit #(.WIDTH(32), .CHUNK(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  alu_flag_unit #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one op (start high for cycle 0), return the cycle done rose in, or -1.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, output int lat);
    lat       = -1;
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc();
      bus.start = 1'b0;
      if (bus.done === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus16.start = 1'b0;
    bus16.a     = '0;
    bus16.b     = '0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.z, bus.n, bus.v} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: busy/done/z/n/v=%b required 00000", {bus.busy, bus.done, bus.z, bus.n, bus.v});
    end
    tests_run++;
    if (bus.diff !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_diff: got %h required 00000000", bus.diff);
    end
    cyc();
    cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_equal();
    bus.a     = 32'd5;
    bus.b     = 32'd5;
    bus.start = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      bus.start = 1'b0;
      tests_run++;
      if (bus.busy !== ((k >= 1) && (k <= 4))) begin
        tests_failed++;
        $display("FAIL equal_busy c%0d: got %b required %b", k, bus.busy, (k >= 1) && (k <= 4));
      end
      tests_run++;
      if (bus.done !== (k == 5)) begin
        tests_failed++;
        $display("FAIL equal_done c%0d: got %b required %b", k, bus.done, k == 5);
      end
      if (k == 5) begin
        tests_run++;
        if ({bus.diff, bus.z, bus.n, bus.v} !== {32'h0, 3'b100}) begin
          tests_failed++;
          $display("FAIL equal_result: diff=%h znv=%b%b%b required 00000000 100", bus.diff, bus.z, bus.n, bus.v);
        end
      end
    end
  endtask

  task automatic test_negative();
    int lat;
    run_op(32'd3, 32'd7, lat);
    tests_run++;
    if (lat != 5) begin
      tests_failed++;
      $display("FAIL neg_latency: got %0d required 5", lat);
    end
    tests_run++;
    if ({bus.diff, bus.z, bus.n, bus.v} !== {32'hFFFFFFFC, 3'b010}) begin
      tests_failed++;
      $display("FAIL neg_result: diff=%h znv=%b%b%b required fffffffc 010", bus.diff, bus.z, bus.n, bus.v);
    end
    for (int k = 0; k < 3; k++) cyc();
    tests_run++;
    if ({bus.diff, bus.z, bus.n, bus.v, bus.done} !== {32'hFFFFFFFC, 4'b0100}) begin
      tests_failed++;
      $display("FAIL neg_hold: diff=%h znv=%b%b%b done=%b required fffffffc 010 0", bus.diff, bus.z, bus.n, bus.v, bus.done);
    end
  endtask

  task automatic test_overflow();
    int lat;
    run_op(32'h7FFFFFFF, 32'hFFFFFFFF, lat);
    tests_run++;
    if (lat != 5 || {bus.diff, bus.z, bus.n, bus.v} !== {32'h80000000, 3'b011}) begin
      tests_failed++;
      $display("FAIL ovf_pos: lat=%0d diff=%h znv=%b%b%b required 5 80000000 011", lat, bus.diff, bus.z, bus.n, bus.v);
    end
    run_op(32'h80000000, 32'h00000001, lat);
    tests_run++;
    if (lat != 5 || {bus.diff, bus.z, bus.n, bus.v} !== {32'h7FFFFFFF, 3'b001}) begin
      tests_failed++;
      $display("FAIL ovf_neg: lat=%0d diff=%h znv=%b%b%b required 5 7fffffff 001", lat, bus.diff, bus.z, bus.n, bus.v);
    end
  endtask

  task automatic test_cross_slice();
    int lat;
    run_op(32'h01000000, 32'h0, lat);
    tests_run++;
    if (lat != 5 || {bus.diff, bus.z, bus.n, bus.v} !== {32'h01000000, 3'b000}) begin
      tests_failed++;
      $display("FAIL xslice_zero: lat=%0d diff=%h znv=%b%b%b required 5 01000000 000", lat, bus.diff, bus.z, bus.n, bus.v);
    end
    run_op(32'h00000100, 32'h00000001, lat);
    tests_run++;
    if (lat != 5 || {bus.diff, bus.z, bus.n, bus.v} !== {32'h000000FF, 3'b000}) begin
      tests_failed++;
      $display("FAIL xslice_borrow: lat=%0d diff=%h znv=%b%b%b required 5 000000ff 000", lat, bus.diff, bus.z, bus.n, bus.v);
    end
  endtask

  // start held high throughout; operands change every cycle but only cycles 0/5/10 count.
  task automatic test_back_to_back();
    logic [31:0] exp_diff;
    logic        exp_done;
    logic        exp_busy;
    logic        prev_done;
    prev_done = 1'b0;
    for (int k = 0; k <= 15; k++) begin
      exp_done = (k == 5) || (k == 10) || (k == 15);
      exp_busy = (k > 0) && ((k % 5) != 0);
      if (k > 0) begin
        tests_run++;
        if (bus.done !== exp_done || bus.busy !== exp_busy) begin
          tests_failed++;
          $display("FAIL b2b_ctrl c%0d: done=%b busy=%b required %b %b", k, bus.done, bus.busy, exp_done, exp_busy);
        end
        tests_run++;
        if (bus.done === 1'b1 && prev_done === 1'b1) begin
          tests_failed++;
          $display("FAIL b2b_done_twice c%0d: done=1 in consecutive cycles, required single pulse", k);
        end
        prev_done = bus.done;
      end
      if (exp_done) begin
        exp_diff = (k == 5) ? 32'd7 : (k == 10) ? 32'd15 : 32'hFFFFFFFE;
        tests_run++;
        if (bus.diff !== exp_diff || bus.n !== exp_diff[31]) begin
          tests_failed++;
          $display("FAIL b2b_result c%0d: diff=%h n=%b required %h %b", k, bus.diff, bus.n, exp_diff, exp_diff[31]);
        end
      end
      if (k == 0) begin
        bus.a = 32'd10; bus.b = 32'd3;
      end else if (k == 5) begin
        bus.a = 32'd20; bus.b = 32'd5;
      end else if (k == 10) begin
        bus.a = 32'd7;  bus.b = 32'd9;
      end else begin
        bus.a = 32'(k * 1000 + 1); bus.b = 32'h55;
      end
      bus.start = (k < 15);
      cyc();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    bus.a     = 32'd9;
    bus.b     = 32'd2;
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    reset_n = 1'b0;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.z, bus.n, bus.v} !== 5'b0 || bus.diff !== 32'h0) begin
      tests_failed++;
      $display("FAIL rstmid_outputs: busy/done/z/n/v=%b diff=%h required 00000 00000000",
               {bus.busy, bus.done, bus.z, bus.n, bus.v}, bus.diff);
    end
    for (int k = 0; k < 3; k++) begin
      cyc();
      tests_run++;
      if (bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_no_done c%0d: done=%b required 0", k, bus.done);
      end
    end
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc();
      tests_run++;
      if (bus.done !== 1'b0) begin
        tests_failed++;
        $display("FAIL rstmid_stale_done c%0d: done=%b required 0", k, bus.done);
      end
    end
    run_op(32'd9, 32'd2, lat);
    tests_run++;
    if (lat != 5 || {bus.diff, bus.z, bus.n, bus.v} !== {32'd7, 3'b000}) begin
      tests_failed++;
      $display("FAIL rstmid_after: lat=%0d diff=%h znv=%b%b%b required 5 00000007 000", lat, bus.diff, bus.z, bus.n, bus.v);
    end
  endtask

  task automatic test_single_chunk();
    bus16.a     = 16'd5;
    bus16.b     = 16'd7;
    bus16.start = 1'b1;
    cyc();
    bus16.start = 1'b0;
    tests_run++;
    if (bus16.busy !== 1'b1 || bus16.done !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_c1: busy=%b done=%b required 1 0", bus16.busy, bus16.done);
    end
    cyc();
    tests_run++;
    if (bus16.busy !== 1'b0 || bus16.done !== 1'b1 || {bus16.diff, bus16.z, bus16.n, bus16.v} !== {16'hFFFE, 3'b010}) begin
      tests_failed++;
      $display("FAIL single_c2: busy=%b done=%b diff=%h znv=%b%b%b required 0 1 fffe 010",
               bus16.busy, bus16.done, bus16.diff, bus16.z, bus16.n, bus16.v);
    end
    bus16.a     = 16'h8000;
    bus16.b     = 16'h0001;
    bus16.start = 1'b1;
    cyc();
    bus16.start = 1'b0;
    cyc();
    tests_run++;
    if (bus16.done !== 1'b1 || {bus16.diff, bus16.z, bus16.n, bus16.v} !== {16'h7FFF, 3'b001}) begin
      tests_failed++;
      $display("FAIL single_b2b: done=%b diff=%h znv=%b%b%b required 1 7fff 001",
               bus16.done, bus16.diff, bus16.z, bus16.n, bus16.v);
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_equal();
    test_negative();
    test_overflow();
    test_cross_slice();
    test_back_to_back();
    cyc();
    test_reset_mid();
    test_single_chunk();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/alu_flag_unit.md
# alu_flag_unit

Multi-cycle subtract-and-flag engine that produces the zero, overflow and negative flags (`z`, `v`, `n`) consumed by the compare-result logic for cmpeq/cmplt/cmple. It computes `a - b` in CHUNK-bit slices, LSB first, with a registered carry chain. It presents the difference and the three flags together with a one-cycle `done` pulse. It sits beside the ALU and drives the flag inputs of the compare stage. Flags are held stable between operations.

## Interface
- `WIDTH`, default 32: operand and difference width. Must be a multiple of CHUNK.
- `CHUNK`, default 8: bits processed per cycle, 1..WIDTH. NCHUNK = WIDTH/CHUNK.

- `clk`  in  1: single clock, rising edge.
- `reset_n`  in  1: asynchronous, active-low reset.
- `start`  in  1: request; sampled on rising edge; accepted only in IDLE or DONE.
- `a`  in  WIDTH: minuend, two's complement; captured on accepted start.
- `b`  in  WIDTH: subtrahend, two's complement; captured on accepted start.
- `busy`  out  1: high while slices are being computed (RUN).
- `done`  out  1: one-cycle pulse; result and flags valid and newly updated.
- `diff`  out  WIDTH: `a - b` mod 2^WIDTH; held until the next done.
- `z`  out  1: diff == 0.
- `n`  out  1: diff[WIDTH-1].
- `v`  out  1: signed overflow of `a - b`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - On `start`, latch `a` and `~b`.
  - Set carry to 1, slice index to 0, zero_acc to 1.
  - Go to RUN.
- RUN, slice i (bits [i*CHUNK +: CHUNK]):
  - sum = a_slice + nb_slice + carry, CHUNK+1 bits.
  - Write the low CHUNK bits into the internal diff register.
  - carry <= sum[CHUNK].
  - zero_acc <= zero_acc & (slice == 0).
  - i increments; after slice NCHUNK-1, go to DONE.
- Final slice, computed from latched operands:
  - n = result MSB.
  - v = (a[MSB] != b[MSB]) & (result MSB != a[MSB]).
  - z = zero_acc & (final slice == 0).
- DONE (one cycle):
  - `done`=1.
  - `diff`/`z`/`n`/`v` outputs update at the DONE entry edge.
  - `start` here is accepted (back-to-back) → RUN; otherwise → IDLE.
- `start` in RUN is ignored and has no side effects.
- Output flags and `diff` change only at DONE entry or reset. Internal partial results never appear on the outputs.
- `reset_n` low at any time:
  - State → IDLE; index, carry and zero_acc cleared.
  - All outputs 0: `busy`=0, `done`=0, `diff`=0, `z`=0, `n`=0, `v`=0.
  - Any in-flight operation is discarded; no `done` is produced for it.

## Timing
- Start sampled high at end of cycle 0.
- `busy`=1 in cycles 1..NCHUNK; slice i is computed in cycle i+1.
- `done`=1 in cycle NCHUNK+1, with `busy`=0 and outputs valid in that same cycle.
- Latency start→done = NCHUNK+1 cycles (5 at defaults). Throughput: one operation per NCHUNK+1 cycles with back-to-back starts.
- CHUNK=WIDTH: one RUN cycle, done in cycle 2.
- `done` is never high two consecutive cycles.
- `busy` and `done` are never high together.
- Reset release: first `start` may be sampled on the first rising edge with `reset_n` high.

## Test plan
- Equal operands, a=5, b=5, defaults:
  - `busy` high in cycles 1-4, `done` in cycle 5.
  - diff=0, z=1, n=0, v=0.
- Negative result, a=3, b=7: diff=0xFFFFFFFC, n=1, z=0, v=0.
- Overflow:
  - a=0x7FFFFFFF, b=0xFFFFFFFF: diff=0x80000000, n=1, v=1, z=0.
  - a=0x80000000, b=1: diff=0x7FFFFFFF, n=0, v=1.
- Cross-slice zero/carry:
  - a=0x01000000, b=0: z=0, n=0.
  - a=0x00000100, b=0x00000001: diff=0x000000FF (borrow across slice), z=0.
- Handshake:
  - `start` held high continuously: ops complete in cycles 5, 10, 15.
  - New operands presented during RUN are ignored; only operands sampled in IDLE/DONE are used.
- Reset mid-operation:
  - Drop `reset_n` in cycle 2 of a=9, b=2: all outputs 0 immediately; no `done`.
  - After release, a=9, b=2 gives diff=7, z=n=v=0, `done` 5 cycles after start.
